// File: rtl/cap_sense_pkg.sv
// Shared state encoding and parameter defaults for the capacitive touch scanner.
package cap_sense_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_DISCHARGE = 2'd1,
    ST_CHARGE    = 2'd2,
    ST_EVAL      = 2'd3
  } cap_sense_state_e;

  localparam int DEF_NUM_CH           = 9;
  localparam int DEF_CNT_W            = 16;
  localparam int DEF_DISCHARGE_CYCLES = 256;
  localparam int DEF_TIMEOUT          = 4095;
  localparam int DEF_THRESHOLD        = 200;
  localparam int DEF_DEBOUNCE         = 3;

endpackage

// File: rtl/cap_sense_channel.sv
// One sense channel: input synchroniser, first-edge charge-time capture,
// committed count, debounced touch state and press pulse.
module cap_sense_channel
  import cap_sense_pkg::*;
#(
  parameter int CNT_W     = DEF_CNT_W,
  parameter int TIMEOUT   = DEF_TIMEOUT,
  parameter int THRESHOLD = DEF_THRESHOLD,
  parameter int DEBOUNCE  = DEF_DEBOUNCE
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             sense_i,
  input  logic             clear_i,
  input  logic             charge_i,
  input  logic             eval_i,
  input  logic [CNT_W-1:0] timer_i,
  output logic             done_o,
  output logic [CNT_W-1:0] count_o,
  output logic             touched_o,
  output logic             press_o
);

  localparam int DB_W = $clog2(DEBOUNCE + 1);

  logic             sync1_q, sync2_q;
  logic             done_q, done_d;
  logic [CNT_W-1:0] work_q, work_d;
  logic [CNT_W-1:0] result_q, result_d;
  logic             touched_q, touched_d;
  logic [DB_W-1:0]  agree_q, agree_d;
  logic             press_q, press_d;
  logic             raw_touch;

  always_comb begin
    done_d    = done_q;
    work_d    = work_q;
    result_d  = result_q;
    touched_d = touched_q;
    agree_d   = agree_q;
    raw_touch = 1'b0;
    if (clear_i) begin
      done_d = 1'b0;
      work_d = '0;
    end else if (charge_i && sync2_q && !done_q) begin
      done_d = 1'b1;
      work_d = timer_i;
    end
    // A channel that never saw its edge reads as the full timeout.
    if (eval_i) begin
      result_d  = done_q ? work_q : CNT_W'(TIMEOUT);
      raw_touch = (result_d >= CNT_W'(THRESHOLD));
      if (raw_touch == touched_q) begin
        agree_d = '0;
      end else if (agree_q >= DB_W'(DEBOUNCE - 1)) begin
        touched_d = ~touched_q;
        agree_d   = '0;
      end else begin
        agree_d = agree_q + 1'b1;
      end
    end
    press_d = touched_d & ~touched_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      done_q    <= 1'b0;
      work_q    <= '0;
      result_q  <= '0;
      touched_q <= 1'b0;
      agree_q   <= '0;
      press_q   <= 1'b0;
    end else begin
      sync1_q   <= sense_i;
      sync2_q   <= sync1_q;
      done_q    <= done_d;
      work_q    <= work_d;
      result_q  <= result_d;
      touched_q <= touched_d;
      agree_q   <= agree_d;
      press_q   <= press_d;
    end
  end

  assign done_o    = done_q;
  assign count_o   = result_q;
  assign touched_o = touched_q;
  assign press_o   = press_q;

endmodule

// File: rtl/cap_sense_scanner.sv
// Capacitive touch scanner: discharge all pads, drive the shared charge pin and
// time each channel's rising edge, then commit counts and debounce touch states.
module cap_sense_scanner
  import cap_sense_pkg::*;
#(
  parameter int NUM_CH           = DEF_NUM_CH,
  parameter int CNT_W            = DEF_CNT_W,
  parameter int DISCHARGE_CYCLES = DEF_DISCHARGE_CYCLES,
  parameter int TIMEOUT          = DEF_TIMEOUT,
  parameter int THRESHOLD        = DEF_THRESHOLD,
  parameter int DEBOUNCE         = DEF_DEBOUNCE
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [NUM_CH-1:0]         capacitive_sensors_in,
  output logic                      capacitive_sensors_out,
  output logic [NUM_CH-1:0]         touched,
  output logic [NUM_CH-1:0]         press_pulse,
  output logic                      scan_done,
  input  logic [$clog2(NUM_CH)-1:0] rd_sel,
  output logic [CNT_W-1:0]          rd_count,
  output cap_sense_state_e          dbg_state_o
);

  localparam int RD_W   = $clog2(NUM_CH);
  localparam int DISC_W = $clog2(DISCHARGE_CYCLES + 1);

  cap_sense_state_e  state_q, state_d;
  logic [CNT_W-1:0]  timer_q, timer_d;
  logic [DISC_W-1:0] disc_q, disc_d;
  logic [NUM_CH-1:0] done;
  logic [CNT_W-1:0]  counts [NUM_CH];
  logic              all_done;

  assign all_done = &done;

  // The timer saturates at TIMEOUT, so it can never wrap during a long charge.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    disc_d  = '0;
    case (state_q)
      ST_IDLE: begin
        timer_d = '0;
        if (enable) state_d = ST_DISCHARGE;
      end
      ST_DISCHARGE: begin
        timer_d = '0;
        disc_d  = disc_q + 1'b1;
        if (disc_q == DISC_W'(DISCHARGE_CYCLES - 1)) state_d = ST_CHARGE;
      end
      ST_CHARGE: begin
        if (timer_q != CNT_W'(TIMEOUT)) timer_d = timer_q + 1'b1;
        if (all_done || (timer_q == CNT_W'(TIMEOUT))) state_d = ST_EVAL;
      end
      ST_EVAL: begin
        timer_d = '0;
        state_d = enable ? ST_DISCHARGE : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      timer_q <= '0;
      disc_q  <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      disc_q  <= disc_d;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    cap_sense_channel #(
      .CNT_W     (CNT_W),
      .TIMEOUT   (TIMEOUT),
      .THRESHOLD (THRESHOLD),
      .DEBOUNCE  (DEBOUNCE)
    ) u_ch (
      .clk_i     (clock),
      .rst_i     (reset),
      .sense_i   (capacitive_sensors_in[g]),
      .clear_i   (state_q == ST_DISCHARGE),
      .charge_i  (state_q == ST_CHARGE),
      .eval_i    (state_q == ST_EVAL),
      .timer_i   (timer_q),
      .done_o    (done[g]),
      .count_o   (counts[g]),
      .touched_o (touched[g]),
      .press_o   (press_pulse[g])
    );
  end

  always_comb begin
    rd_count = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (rd_sel == RD_W'(i)) rd_count = counts[i];
    end
  end

  assign capacitive_sensors_out = (state_q == ST_CHARGE);
  assign scan_done              = (state_q == ST_EVAL);
  assign dbg_state_o            = state_q;

endmodule

// File: tb/tb_cap_sense_scanner.sv
// Randomised scan bench for cap_sense_scanner: per-channel edge delays are
// turned into expected counts, charge lengths and debounced touch states.
module tb_cap_sense_scanner;
  import cap_sense_pkg::*;

  localparam int NUM_CH           = 9;
  localparam int CNT_W            = 16;
  localparam int DISCHARGE_CYCLES = 8;
  localparam int TIMEOUT          = 100;
  localparam int THRESHOLD        = 40;
  localparam int DEBOUNCE         = 2;
  localparam int NEVER            = 1000;

  logic                clock = 1'b0;
  logic                reset;
  logic                enable;
  logic [NUM_CH-1:0]   sens_in;
  logic                sens_out;
  logic [NUM_CH-1:0]   touched;
  logic [NUM_CH-1:0]   press_pulse;
  logic                scan_done;
  logic [3:0]          rd_sel;
  logic [CNT_W-1:0]    rd_count;
  cap_sense_state_e    dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  // dly[i]: cycles after the charge pin rises at which pad i goes high;
  // -1 means already high before charge started.
  int                dly     [NUM_CH];
  int                m_count [NUM_CH];
  int                m_agree [NUM_CH];
  logic [NUM_CH-1:0] m_touched;
  logic [NUM_CH-1:0] m_press;

  cap_sense_scanner #(
    .NUM_CH           (NUM_CH),
    .CNT_W            (CNT_W),
    .DISCHARGE_CYCLES (DISCHARGE_CYCLES),
    .TIMEOUT          (TIMEOUT),
    .THRESHOLD        (THRESHOLD),
    .DEBOUNCE         (DEBOUNCE)
  ) dut (
    .clock                  (clock),
    .reset                  (reset),
    .enable                 (enable),
    .capacitive_sensors_in  (sens_in),
    .capacitive_sensors_out (sens_out),
    .touched                (touched),
    .press_pulse            (press_pulse),
    .scan_done              (scan_done),
    .rd_sel                 (rd_sel),
    .rd_count               (rd_count),
    .dbg_state_o            (dbg_state)
  );

  always #5 clock = ~clock;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_touched = '0;
    m_press   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      m_count[i] = 0;
      m_agree[i] = 0;
    end
  endtask

  task automatic drive_edges(input int k);
    for (int i = 0; i < NUM_CH; i++)
      if (dly[i] == k) sens_in[i] = 1'b1;
  endtask

  // Expected counts and debounce outcome of one scan; returns expected CHARGE length.
  task automatic model_scan(output int exp_len);
    int c, mx;
    bit raw;
    mx = 0;
    m_press = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (dly[i] < 0) c = 0;
      else if (dly[i] + 2 > TIMEOUT) c = TIMEOUT;
      else c = dly[i] + 2;
      m_count[i] = c;
      if (c > mx) mx = c;
      raw = (c >= THRESHOLD);
      if (raw == m_touched[i]) begin
        m_agree[i] = 0;
      end else begin
        m_agree[i]++;
        if (m_agree[i] == DEBOUNCE) begin
          m_touched[i] = ~m_touched[i];
          m_agree[i]   = 0;
          if (m_touched[i]) m_press[i] = 1'b1;
        end
      end
    end
    exp_len = (mx >= TIMEOUT) ? TIMEOUT + 1 : mx + 2;
  endtask

  task automatic run_scan(input int rise_exp, input logic [NUM_CH-1:0] pre_next);
    int  n, len, exp_len;
    bit  risen, done;
    risen = 1'b0;
    for (n = 1; n <= 400; n++) begin
      @(posedge clock); #1;
      if (sens_out) begin
        risen = 1'b1;
        break;
      end
    end
    check_eq("rise_seen", risen, 1);
    if (!risen) return;
    if (rise_exp >= 0) check_eq("rise_cycles", n, rise_exp);
    len = 1;
    drive_edges(0);
    done = 1'b0;
    for (int k = 1; k <= 300; k++) begin
      @(posedge clock); #1;
      if (scan_done) begin
        done = 1'b1;
        break;
      end
      if (sens_out) len++;
      drive_edges(k);
    end
    check_eq("scan_done_seen", done, 1);
    sens_in = pre_next;
    model_scan(exp_len);
    check_eq("charge_len", len, exp_len);
    @(posedge clock); #1;
    check_eq("scan_done_once", scan_done, 0);
    check_eq("touched", touched, m_touched);
    check_eq("press_pulse", press_pulse, m_press);
    @(posedge clock); #1;
    check_eq("press_one_cycle", press_pulse, 0);
    for (int s = 0; s < 16; s++) begin
      rd_sel = 4'(s);
      #1;
      check_eq($sformatf("rd_count[%0d]", s), rd_count, (s < NUM_CH) ? m_count[s] : 0);
    end
  endtask

  task automatic set_dly_all(input int v);
    for (int i = 0; i < NUM_CH; i++) dly[i] = v;
  endtask

  initial begin
    logic [NUM_CH-1:0] pre;
    logic [NUM_CH-1:0] pre_nxt;
    bit risen;

    reset   = 1'b1;
    enable  = 1'b1;
    sens_in = '0;
    rd_sel  = '0;
    model_reset();
    repeat (3) @(posedge clock);
    #1;
    check_eq("rst_drive", sens_out, 0);
    check_eq("rst_touched", touched, 0);
    check_eq("rst_press", press_pulse, 0);
    check_eq("rst_scan_done", scan_done, 0);
    check_eq("rst_rd_count", rd_count, 0);
    reset = 1'b0;

    // Uniform edges: every count identical, nothing touched.
    set_dly_all(10);
    run_scan(1 + DISCHARGE_CYCLES, '0);

    // Channel 4 slow, others fast: touched only after the second agreeing scan.
    set_dly_all(8);
    dly[4] = 48;
    run_scan(-1, '0);
    check_eq("no_touch_after_one", touched[4], 0);
    run_scan(-1, '0);
    check_eq("touch_after_two", touched[4], 1);

    // Channel 0 never rises: timeout count and full-length charge.
    for (int i = 0; i < NUM_CH; i++) dly[i] = $urandom_range(0, 30);
    dly[0] = NEVER;
    run_scan(-1, 9'b010000100);

    // Pads already high at charge start read as zero.
    for (int i = 0; i < NUM_CH; i++) dly[i] = $urandom_range(0, 60);
    dly[2] = -1;
    dly[7] = -1;
    run_scan(-1, '0);

    pre = '0;
    for (int r = 0; r < 10; r++) begin
      pre_nxt = NUM_CH'($urandom_range(0, 511) & $urandom_range(0, 511) & $urandom_range(0, 511));
      for (int i = 0; i < NUM_CH; i++) begin
        if (pre[i]) dly[i] = -1;
        else if ($urandom_range(0, 7) == 0) dly[i] = NEVER;
        else dly[i] = $urandom_range(0, 110);
      end
      run_scan(-1, pre_nxt);
      pre = pre_nxt;
    end

    // Prime channel 4 touched, then reset in the middle of a charge phase.
    for (int i = 0; i < NUM_CH; i++) dly[i] = pre[i] ? -1 : 8;
    dly[4] = pre[4] ? -1 : 48;
    run_scan(-1, '0);
    set_dly_all(8);
    dly[4] = 48;
    run_scan(-1, '0);
    check_eq("primed_touch", touched[4], 1);
    risen = 1'b0;
    for (int n = 0; n < 400; n++) begin
      @(posedge clock); #1;
      if (sens_out) begin
        risen = 1'b1;
        break;
      end
    end
    check_eq("mid_rise_seen", risen, 1);
    repeat (20) @(posedge clock);
    #3;
    check_eq("mid_charge_drive", sens_out, 1);
    reset  = 1'b1;
    rd_sel = 4'd4;
    #1;
    check_eq("mid_rst_drive", sens_out, 0);
    check_eq("mid_rst_touched", touched, 0);
    check_eq("mid_rst_press", press_pulse, 0);
    check_eq("mid_rst_scan_done", scan_done, 0);
    check_eq("mid_rst_rd_count", rd_count, 0);
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    set_dly_all(20);
    run_scan(1 + DISCHARGE_CYCLES, '0);

    // Drop enable during discharge: scan still completes, then idles.
    enable = 1'b0;
    for (int i = 0; i < NUM_CH; i++) dly[i] = $urandom_range(0, 70);
    run_scan(-1, '0);
    for (int c = 0; c < 12; c++) begin
      @(posedge clock); #1;
      check_eq("idle_drive", sens_out, 0);
      check_eq("idle_scan_done", scan_done, 0);
    end
    check_eq("idle_state", dbg_state, ST_IDLE);
    enable = 1'b1;
    for (int i = 0; i < NUM_CH; i++) dly[i] = $urandom_range(0, 110);
    run_scan(1 + DISCHARGE_CYCLES, '0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
